// File: rtl/rx_frame_admit.sv
// Admission gate between a MAC RX byte stream and a packet FIFO: drops, truncates or passes frames.
// Optional statistics counters are built when RX_ADMIT_STATS_EN is defined.
module rx_frame_admit #(
    parameter int MAX_LEN = 1518,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             rx_sof,
    input  logic             rx_last,
    output logic [7:0]       di,
    output logic             we,
    output logic             EOD_in,
    input  logic             full_flag,
    input  logic             afull_flag,
    output logic             busy,
    output logic             drop_pulse,
    output logic             trunc_pulse
`ifdef RX_ADMIT_STATS_EN
    ,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_drop,
    output logic [CNT_W-1:0] frames_trunc
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        PASS,
        DROP,
        TERM,
        DISCARD
    } state_t;

    localparam logic [10:0] MAX_L = 11'(MAX_LEN);

    state_t      state_q, state_d;
    logic [10:0] len_q, len_d;
    logic        last_seen_q, last_seen_d;
    logic        drop_pulse_q, drop_pulse_d;
    logic        trunc_pulse_q, trunc_pulse_d;
    logic        ok_d;
    logic        we_raw;
    logic [10:0] len_inc;
    logic        at_max;

    assign len_inc = (len_q == 11'h7ff) ? len_q : len_q + 11'd1;
    assign at_max  = (len_inc >= MAX_L);

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        last_seen_d   = last_seen_q;
        drop_pulse_d  = 1'b0;
        trunc_pulse_d = 1'b0;
        ok_d          = 1'b0;
        di            = rx_data;
        we_raw        = 1'b0;
        EOD_in        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_valid && rx_sof) begin
                    // full is checked too so a write never lands on a full FIFO
                    if (afull_flag || full_flag) begin
                        drop_pulse_d = 1'b1;
                        state_d      = rx_last ? IDLE : DROP;
                    end else begin
                        we_raw  = 1'b1;
                        EOD_in  = rx_last;
                        len_d   = 11'd1;
                        state_d = rx_last ? IDLE : PASS;
                    end
                end
            end
            PASS: begin
                if (rx_valid) begin
                    if (full_flag) begin
                        trunc_pulse_d = 1'b1;
                        last_seen_d   = rx_last;
                        state_d       = TERM;
                    end else begin
                        we_raw = 1'b1;
                        len_d  = len_inc;
                        EOD_in = rx_last || at_max;
                        if (rx_last) begin
                            ok_d    = 1'b1;
                            state_d = IDLE;
                        end else if (at_max) begin
                            trunc_pulse_d = 1'b1;
                            state_d       = DISCARD;
                        end
                    end
                end
            end
            TERM: begin
                if (!full_flag) begin
                    // a last byte arriving with the terminator still ends the frame
                    we_raw      = 1'b1;
                    di          = 8'h00;
                    EOD_in      = 1'b1;
                    last_seen_d = 1'b0;
                    state_d     = (last_seen_q || (rx_valid && rx_last))
                                  ? IDLE : DISCARD;
                end else if (rx_valid && rx_last) begin
                    last_seen_d = 1'b1;
                end
            end
            DROP, DISCARD: begin
                if (rx_valid && rx_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        we = we_raw && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            len_q         <= 11'd0;
            last_seen_q   <= 1'b0;
            drop_pulse_q  <= 1'b0;
            trunc_pulse_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            last_seen_q   <= last_seen_d;
            drop_pulse_q  <= drop_pulse_d;
            trunc_pulse_q <= trunc_pulse_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign drop_pulse  = drop_pulse_q;
    assign trunc_pulse = trunc_pulse_q;

`ifdef RX_ADMIT_STATS_EN
    logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] trunc_cnt_q, trunc_cnt_d;

    always_comb begin
        ok_cnt_d    = ok_cnt_q + {{(CNT_W-1){1'b0}}, ok_d};
        drop_cnt_d  = drop_cnt_q + {{(CNT_W-1){1'b0}}, drop_pulse_d};
        trunc_cnt_d = trunc_cnt_q + {{(CNT_W-1){1'b0}}, trunc_pulse_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ok_cnt_q    <= '0;
            drop_cnt_q  <= '0;
            trunc_cnt_q <= '0;
        end else begin
            ok_cnt_q    <= ok_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
        end
    end

    assign frames_ok    = ok_cnt_q;
    assign frames_drop  = drop_cnt_q;
    assign frames_trunc = trunc_cnt_q;
`endif

endmodule

// File: tb/tb_rx_frame_admit.sv
// Bench for rx_frame_admit: directed frame scenarios plus randomized traffic,
// checked every cycle against a frame-level reference model.
module tb_rx_frame_admit;

    localparam int MAX_LEN = 1518;
    localparam int CNT_W   = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       rx_data = 8'h00;
    logic             rx_valid = 1'b0;
    logic             rx_sof = 1'b0;
    logic             rx_last = 1'b0;
    logic [7:0]       di;
    logic             we;
    logic             EOD_in;
    logic             full_flag = 1'b0;
    logic             afull_flag = 1'b0;
    logic             busy;
    logic             drop_pulse;
    logic             trunc_pulse;
`ifdef RX_ADMIT_STATS_EN
    logic [CNT_W-1:0] frames_ok;
    logic [CNT_W-1:0] frames_drop;
    logic [CNT_W-1:0] frames_trunc;
`endif

    rx_frame_admit #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_sof      (rx_sof),
        .rx_last     (rx_last),
        .di          (di),
        .we          (we),
        .EOD_in      (EOD_in),
        .full_flag   (full_flag),
        .afull_flag  (afull_flag),
        .busy        (busy),
        .drop_pulse  (drop_pulse),
        .trunc_pulse (trunc_pulse)
`ifdef RX_ADMIT_STATS_EN
        ,
        .frames_ok   (frames_ok),
        .frames_drop (frames_drop),
        .frames_trunc(frames_trunc)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: where the current frame stands, not how the RTL encodes it.
    localparam int F_NONE  = 0; // between frames
    localparam int F_WRITE = 1; // frame being copied to the FIFO
    localparam int F_SKIP  = 2; // rest of frame thrown away
    localparam int F_OWE   = 3; // frame cut short, terminator still owed
    int          m_where = F_NONE;
    int          m_len   = 0;
    bit          m_ended = 1'b0;
    bit          m_drop  = 1'b0;
    bit          m_trunc = 1'b0;
    logic [15:0] n_ok = 0, n_drop = 0, n_trunc = 0;

    // Observations of the DUT write port for the directed literal checks.
    int   obs_wr = 0, obs_eod = 0, obs_eod_at = 0, obs_drop = 0, obs_trunc = 0;
    int   obs_last_di = 0;
    int   burst = 0;

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_cycle();
        bit          e_we;
        bit          e_eod;
        logic [7:0]  e_di;
        e_we  = 1'b0;
        e_eod = 1'b0;
        e_di  = 8'h00;
        chk("busy", int'(busy), int'(m_where != F_NONE));
        chk("drop_pulse", int'(drop_pulse), int'(m_drop));
        chk("trunc_pulse", int'(trunc_pulse), int'(m_trunc));
`ifdef RX_ADMIT_STATS_EN
        chk("frames_ok", int'(frames_ok), int'(n_ok));
        chk("frames_drop", int'(frames_drop), int'(n_drop));
        chk("frames_trunc", int'(frames_trunc), int'(n_trunc));
`endif
        m_drop  = 1'b0;
        m_trunc = 1'b0;
        if (rst) begin
            m_where = F_NONE;
            m_len   = 0;
            m_ended = 1'b0;
            n_ok    = 0;
            n_drop  = 0;
            n_trunc = 0;
        end else if (m_where == F_NONE) begin
            if (rx_valid && rx_sof) begin
                if (afull_flag || full_flag) begin
                    m_drop  = 1'b1;
                    n_drop  = n_drop + 1;
                    m_where = rx_last ? F_NONE : F_SKIP;
                end else begin
                    e_we    = 1'b1;
                    e_di    = rx_data;
                    e_eod   = rx_last;
                    m_len   = 1;
                    m_where = rx_last ? F_NONE : F_WRITE;
                end
            end
        end else if (m_where == F_WRITE) begin
            if (rx_valid && full_flag) begin
                m_trunc = 1'b1;
                n_trunc = n_trunc + 1;
                m_ended = rx_last;
                m_where = F_OWE;
            end else if (rx_valid) begin
                e_we  = 1'b1;
                e_di  = rx_data;
                m_len = (m_len + 1 > 2047) ? 2047 : m_len + 1;
                e_eod = rx_last || (m_len >= MAX_LEN);
                if (rx_last) begin
                    n_ok    = n_ok + 1;
                    m_where = F_NONE;
                end else if (m_len >= MAX_LEN) begin
                    m_trunc = 1'b1;
                    n_trunc = n_trunc + 1;
                    m_where = F_SKIP;
                end
            end
        end else if (m_where == F_OWE) begin
            if (!full_flag) begin
                e_we    = 1'b1;
                e_di    = 8'h00;
                e_eod   = 1'b1;
                m_where = (m_ended || (rx_valid && rx_last)) ? F_NONE : F_SKIP;
                m_ended = 1'b0;
            end else if (rx_valid && rx_last) begin
                m_ended = 1'b1;
            end
        end else begin
            if (rx_valid && rx_last) m_where = F_NONE;
        end
        chk("we", int'(we), int'(e_we));
        if (e_we) begin
            chk("di", int'(di), int'(e_di));
            chk("EOD_in", int'(EOD_in), int'(e_eod));
        end
        if (we && full_flag) chk("we_while_full", 1, 0);
        if (we) begin
            obs_wr++;
            obs_last_di = int'(di);
            if (EOD_in) begin
                obs_eod++;
                obs_eod_at = obs_wr;
            end
        end
        if (drop_pulse) obs_drop++;
        if (trunc_pulse) obs_trunc++;
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(bit v, bit s, bit l, bit f, bit af);
        rx_valid   = v;
        rx_sof     = s;
        rx_last    = l;
        rx_data    = 8'($urandom);
        full_flag  = f;
        afull_flag = af | f;
        tick();
    endtask

    task automatic idle(int n, bit f);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, f, 1'b0);
    endtask

    // Bytes ff..ft (1-based) see full high; af raises afull on the SOF byte.
    task automatic frame(int len, int ff, int ft, bit af);
        for (int i = 1; i <= len; i++)
            cyc(1'b1, i == 1, i == len, (i >= ff) && (i <= ft), af && (i == 1));
    endtask

    task automatic rcyc(bit v, bit s, bit l);
        if (burst > 0) burst--;
        else if ($urandom_range(0, 39) == 0) burst = $urandom_range(1, 6);
        cyc(v, s, l, burst > 0, $urandom_range(0, 5) == 0);
    endtask

    int w0, e0, d0, t0;
    task automatic snap();
        w0 = obs_wr;
        e0 = obs_eod;
        d0 = obs_drop;
        t0 = obs_trunc;
    endtask

    initial begin
        rst = 1'b1;
        idle(3, 1'b0);
        rst = 1'b0;
        idle(2, 1'b0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_we", int'(we), 0);
        chk("reset_pulses", int'(drop_pulse | trunc_pulse), 0);

        // 64-byte frame passes intact
        snap();
        frame(64, 0, 0, 1'b0);
        idle(2, 1'b0);
        chk("f64_writes", obs_wr - w0, 64);
        chk("f64_eods", obs_eod - e0, 1);
        chk("f64_eod_pos", obs_eod_at - w0, 64);
`ifdef RX_ADMIT_STATS_EN
        chk("f64_frames_ok", int'(frames_ok), 1);
`endif

        // afull at SOF drops the whole frame; the next one is admitted
        snap();
        frame(100, 0, 0, 1'b1);
        idle(2, 1'b0);
        chk("drop_writes", obs_wr - w0, 0);
        chk("drop_pulses", obs_drop - d0, 1);
`ifdef RX_ADMIT_STATS_EN
        chk("drop_frames_drop", int'(frames_drop), 1);
`endif
        snap();
        frame(10, 0, 0, 1'b0);
        idle(1, 1'b0);
        chk("after_drop_writes", obs_wr - w0, 10);

        // oversize frame is cut at MAX_LEN
        snap();
        frame(2000, 0, 0, 1'b0);
        idle(2, 1'b0);
        chk("long_writes", obs_wr - w0, MAX_LEN);
        chk("long_eod_pos", obs_eod_at - w0, MAX_LEN);
        chk("long_eods", obs_eod - e0, 1);
        chk("long_truncs", obs_trunc - t0, 1);
        snap();
        frame(20, 0, 0, 1'b0);
        idle(1, 1'b0);
        chk("after_long_writes", obs_wr - w0, 20);
        chk("after_long_eods", obs_eod - e0, 1);

        // full for bytes 10..14: 9 data writes plus one terminator
        snap();
        frame(30, 10, 14, 1'b0);
        idle(2, 1'b0);
        chk("full_writes", obs_wr - w0, 10);
        chk("full_eod_pos", obs_eod_at - w0, 10);
        chk("full_term_di", obs_last_di, 0);
        chk("full_truncs", obs_trunc - t0, 1);
        snap();
        frame(12, 0, 0, 1'b0);
        idle(1, 1'b0);
        chk("after_full_writes", obs_wr - w0, 12);

        // full while the last byte arrives: terminator, then straight to idle
        snap();
        frame(8, 8, 8, 1'b0);
        idle(2, 1'b1);
        idle(1, 1'b0);
        chk("lastfull_writes", obs_wr - w0, 8);
        chk("lastfull_term_di", obs_last_di, 0);
        chk("lastfull_busy", int'(busy), 0);
        snap();
        frame(6, 0, 0, 1'b0);
        idle(1, 1'b0);
        chk("after_lastfull_writes", obs_wr - w0, 6);

        // reset mid-frame: tail without SOF must not be written
        snap();
        for (int i = 1; i <= 60; i++) begin
            rst = (i == 30);
            cyc(1'b1, i == 1, i == 60, 1'b0, 1'b0);
        end
        rst = 1'b0;
        chk("rst_mid_writes", obs_wr - w0, 29);
        chk("rst_mid_eods", obs_eod - e0, 0);
        snap();
        frame(5, 0, 0, 1'b0);
        idle(1, 1'b0);
        chk("after_rst_writes", obs_wr - w0, 5);

        // randomized traffic against the model
        for (int f = 0; f < 300; f++) begin
            int len;
            int gap;
            len = ($urandom_range(0, 59) == 0) ? $urandom_range(1520, 1600)
                                               : $urandom_range(2, 60);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++)
                rcyc($urandom_range(0, 3) == 0, 1'b0, $urandom_range(0, 1) == 1);
            for (int i = 1; i <= len; i++) begin
                while ($urandom_range(0, 7) == 0) rcyc(1'b0, 1'b0, 1'b0);
                rst = ($urandom_range(0, 399) == 0);
                rcyc(1'b1, (i == 1) || ($urandom_range(0, 29) == 0), i == len);
                rst = 1'b0;
            end
        end
        idle(10, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rx_frame_admit.md
RX_FRAME_ADMIT -- requirements
Module: rx_frame_admit

Interface
REQ-001 SHALL have parameter MAX_LEN, default 1518, the maximum number of bytes per frame written to the FIFO.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the statistics counters.
REQ-003 SHALL have port clk, input, 1 bit: the single clock. One clock; reset is synchronous and active-high.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports rx_data (input, 8), rx_valid (input, 1), rx_sof (input, 1) and rx_last (input, 1): the MAC RX byte stream, which has no backpressure.
REQ-006 SHALL have ports di (output, 8), we (output, 1) and EOD_in (output, 1): the write side of the downstream packet FIFO.
REQ-007 SHALL have ports full_flag (input, 1) and afull_flag (input, 1), driven from the FIFO.
REQ-008 SHALL have ports busy (output, 1), drop_pulse (output, 1) and trunc_pulse (output, 1): status outputs.
REQ-009 SHALL have ports frames_ok, frames_drop and frames_trunc (output, CNT_W each): statistics counters, present only when the statistics macro is defined.

Function
REQ-010 SHALL drive di, we and EOD_in combinationally from the current state and inputs, so the byte reaches the FIFO in the same cycle as the RX byte; we SHALL never be high while full_flag is high.
REQ-011 SHALL implement the states IDLE, PASS, DROP, TERM and DISCARD.
REQ-012 IDLE: rx_valid without rx_sof SHALL be ignored.
REQ-013 IDLE, rx_valid and rx_sof with afull_flag high: the frame SHALL be dropped, drop_pulse SHALL be 1 for one cycle, and the next state SHALL be DROP (or IDLE if rx_last is also high).
REQ-014 IDLE, rx_valid and rx_sof with afull_flag low: the block SHALL write the byte, set EOD_in=rx_last, load the length counter with 1, and go to PASS (or IDLE if rx_last is high).
REQ-015 PASS, rx_valid with full_flag low: the block SHALL write the byte and increment the length counter; EOD_in=1 when rx_last is high or the counter reaches MAX_LEN; the next state SHALL be IDLE on rx_last, otherwise DISCARD on reaching MAX_LEN (with trunc_pulse), otherwise PASS.
REQ-016 PASS, rx_valid with full_flag high: the byte SHALL be lost and trunc_pulse SHALL be 1 for one cycle; the next state SHALL be TERM, and the block SHALL record last_seen=rx_last.
REQ-017 TERM: while full_flag is high, we SHALL be 0; on the first cycle with full_flag low, the block SHALL write di=8'h00 with EOD_in=1, then go to IDLE if last_seen is set, else DISCARD.
REQ-018 TERM: RX bytes arriving in TERM SHALL be discarded; if rx_last arrives, last_seen SHALL be set; the terminating write SHALL take priority over the incoming byte.
REQ-019 DROP and DISCARD SHALL write nothing and SHALL return to IDLE on rx_valid with rx_last.
REQ-020 rx_sof in any state other than IDLE SHALL be treated as an ordinary byte.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 The length counter SHALL be 11 bits wide and saturating, and SHALL be compared with MAX_LEN using unsigned compare.

Reset
REQ-023 On rst, the state SHALL be IDLE, the length counter and last_seen SHALL be 0, drop_pulse and trunc_pulse SHALL be 0, and all counters SHALL be 0.
REQ-024 While rst is high, we SHALL be 0.
REQ-025 A reset mid-frame SHALL abandon the frame without writing EOD; the FIFO is reset together with this block.

Configuration
REQ-026 The macro RX_ADMIT_STATS_EN SHALL control the statistics counters.
REQ-027 With RX_ADMIT_STATS_EN defined:
- frames_ok SHALL increment on each frame completed in PASS via rx_last.
- frames_drop SHALL increment on each drop_pulse.
- frames_trunc SHALL increment on each trunc_pulse.
- All three SHALL wrap modulo 2^CNT_W.
REQ-028 Without RX_ADMIT_STATS_EN, the three counter ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 64-byte frame, afull low, full low -> 64 writes, EOD_in=1 on the 64th byte only, frames_ok=1.
REQ-030 afull high at SOF of a 100-byte frame -> 0 writes, drop_pulse for 1 cycle, frames_drop=1, and the next frame is admitted once afull is low.
REQ-031 2000-byte frame with MAX_LEN=1518 -> 1518 writes, EOD on byte 1518, trunc_pulse once, the remaining 482 bytes discarded, and the following frame intact.
REQ-032 full rises at byte 10 for 5 cycles -> bytes 10-14 lost, one write of 8'h00 with EOD=1 when full falls, then DISCARD until rx_last, frames_trunc=1.
REQ-033 full high while rx_last arrives -> TERM, 8'h00+EOD written when full clears, return to IDLE with no DISCARD.
REQ-034 rst asserted at byte 30 of a frame, followed by bytes without sof -> no writes until the next rx_sof.
